jk_tff_counter: RTL and testbench
=================================

Name: jk_tff_counter

Overview:
- Synchronous modulo-MOD up/down counter whose state bits are JK flip-flop cells, each wired as a T flip-flop (J = K = T).
- This is the reverse of the T-to-JK conversion. Each cycle the block computes the desired next count, derives the per-bit toggle excitation as T = q XOR next, and drives every JK cell with J = K = T.
- Used as the team's general counting primitive: dividers, sequencers and timeout counters.

Parameters:
- W, 4, counter width in bits (≥ 2).
- MOD, 10, count modulus (2 ≤ MOD ≤ 2^W); the count sequence is 0 .. MOD-1.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, count enable.
- up, input, 1, direction: 1 = increment, 0 = decrement.
- load, input, 1, synchronous parallel load strobe.
- d, input, W, load value.
- q, output, W, current count (the JK cell outputs).
- tc, output, 1, terminal count (combinational).
- load_err, output, 1, registered one-cycle flag: the last load value was out of range.

Behaviour:
- Structure:
  - One JK cell per bit: q_i <= J ? (K ? ~q_i : 1) : (K ? 0 : q_i).
  - Each cell has J_i = K_i = T_i. No bit is written except through its JK cell.
  - The reset and load paths force the cell via its own synchronous controls, not via J/K.
- Priority per rising edge: rst > load > en > hold.
- rst = 1:
  - q <= 0, load_err <= 0.
  - Reset mid-count or mid-load discards that operation.
  - Reset values: q = 0, load_err = 0, tc = 0 unless en = 1 and up = 0 (then tc = 1, since q = 0 counting down).
- load = 1 (rst = 0):
  - If d < MOD: q <= d, load_err <= 0.
  - If d ≥ MOD: q <= 0, load_err <= 1.
  - en and up are ignored that cycle.
- Count (rst = 0, load = 0, en = 1):
  - up = 1: next = (q == MOD-1) ? 0 : q+1.
  - up = 0: next = (q == 0) ? MOD-1 : q-1.
  - T = q ^ next, applied to all cells. Latency: 1 clock.
- Hold (en = 0): T = 0, q unchanged.
- load_err:
  - Set only by an out-of-range load.
  - Cleared on the next edge whose load is 0 or in-range.
  - This makes it a one-cycle pulse unless bad loads are repeated back to back.
- tc = en & ((up & q == MOD-1) | (~up & q == 0)).
  - Purely combinational; asserted during the cycle before the wrap edge.
  - tc does not depend on load or rst.
- Width rules:
  - All compares are W-bit unsigned.
  - MOD-1 is computed as a W-bit constant.
  - When MOD = 2^W, the wrap arithmetic equals natural W-bit overflow and must produce identical results.
- Direction change mid-count takes effect on the same edge; there is no pipeline.
- Parameter checks: elaboration fails if MOD > 2^W or MOD < 2.

Test Plan:
1. Reset and hold (W=4, MOD=10):
   - Stimulus: rst=1 for 2 clocks with en=1, up=1; release rst; hold en=0 for 3 clocks.
   - Required: q=0 and load_err=0 throughout.
2. Up count with wrap:
   - Stimulus: en=1, up=1 for 12 clocks from q=0.
   - Required: q = 1,2,…,9,0,1,2; tc=1 only while q=9; the T pattern at the 9→0 edge is 4'b1001.
3. Down count with wrap:
   - Stimulus: load d=2, then en=1, up=0 for 4 clocks.
   - Required: q = 2,1,0,9,8; tc=1 only while q=0.
4. Load priority and range check:
   - Stimulus A: load=1, d=7, en=1, up=1. Required: q=7 next cycle (not 8), load_err=0.
   - Stimulus B: load=1, d=12. Required: q=0, load_err=1 for exactly one cycle.
5. Reset mid-operation:
   - Stimulus: while counting at q=5, assert rst=1 and load=1 (d=3) together.
   - Required: q=0 and load_err=0 next cycle; counting resumes 1,2,… after rst drops.
6. Full-range modulus (W=3, MOD=8):
   - Stimulus: up-count 9 clocks from 0, then down-count 2.
   - Required: q = 1..7,0,1, then 0,7; tc asserted at q=7 (up) and q=0 (down).

Source files
------------

// File: rtl/jk_tff_counter_if.sv
// Control/status bundle for jk_tff_counter: the counter controls in, the count and flags out.
interface jk_tff_counter_if #(parameter int W = 4);
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         tc;
    logic         load_err;

    modport master (output en, up, load, d, input q, tc, load_err);
    modport slave  (input en, up, load, d, output q, tc, load_err);
endinterface

// File: rtl/jk_tff_counter.sv
// Modulo-MOD up/down counter built from JK cells wired as T flip-flops (J = K = q ^ next).
// Reset and load reach each cell through its own synchronous clear/set controls, never via J/K.
module jk_tff_cell (
    input  logic clk,
    input  logic clr,
    input  logic set,
    input  logic set_val,
    input  logic j,
    input  logic k,
    output logic q
);
    always_ff @(posedge clk) begin
        if (clr)
            q <= 1'b0;
        else if (set)
            q <= set_val;
        else
            q <= j ? (k ? ~q : 1'b1) : (k ? 1'b0 : q);
    end
endmodule

module jk_tff_counter #(
    parameter int W   = 4,
    parameter int MOD = 10
) (
    input  logic           clk,
    input  logic           rst,
    jk_tff_counter_if.slave bus
);
    generate
        if (W < 2 || MOD < 2 || MOD > (1 << W)) begin : g_bad_param
            $error("jk_tff_counter: need W >= 2 and 2 <= MOD <= 2**W");
        end
    endgenerate

    localparam logic [W-1:0] MAX = W'(MOD - 1);

    logic [W-1:0] q;
    logic [W-1:0] nxt;
    logic [W-1:0] t;
    logic [W-1:0] ld_val;
    logic         ld_bad;

    // With MOD = 2**W, MAX is all ones, so the explicit wraps coincide with natural overflow.
    always_comb begin
        nxt = q;
        if (bus.up)
            nxt = (q == MAX) ? '0 : q + W'(1);
        else
            nxt = (q == '0) ? MAX : q - W'(1);
    end

    assign t      = bus.en ? (q ^ nxt) : '0;
    assign ld_bad = bus.d > MAX;
    assign ld_val = ld_bad ? '0 : bus.d;

    for (genvar i = 0; i < W; i++) begin : g_cell
        jk_tff_cell u_cell (
            .clk     (clk),
            .clr     (rst),
            .set     (bus.load),
            .set_val (ld_val[i]),
            .j       (t[i]),
            .k       (t[i]),
            .q       (q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)
            bus.load_err <= 1'b0;
        else
            bus.load_err <= bus.load & ld_bad;
    end

    assign bus.q  = q;
    assign bus.tc = bus.en & ((bus.up & (q == MAX)) | (~bus.up & (q == '0)));
endmodule

// File: tb/tb_jk_tff_counter.sv
// Table-driven bench for jk_tff_counter: one W=4/MOD=10 instance and one W=3/MOD=8 instance.
module tb_jk_tff_counter;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    jk_tff_counter_if #(.W(4)) bus_a ();
    jk_tff_counter_if #(.W(3)) bus_b ();

    jk_tff_counter #(.W(4), .MOD(10)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    jk_tff_counter #(.W(3), .MOD(8))  dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    typedef struct {
        logic       sel;     // 0 = W4/MOD10, 1 = W3/MOD8
        logic       rst, en, up, load;
        logic [3:0] d;
        logic       chk_tc;
        logic       exp_tc;  // tc before the edge
        logic [3:0] exp_q;   // q after the edge
        logic       exp_le;  // load_err after the edge
    } vec_t;

    typedef struct {
        logic       sel;
        logic [3:0] q;
        logic       le;
        int         idx;
    } exp_t;

    vec_t tv[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(logic sel, logic rst, logic en, logic up, logic load,
                                logic [3:0] d, logic chk_tc, logic exp_tc,
                                logic [3:0] exp_q, logic exp_le);
        vec_t v;
        v.sel = sel; v.rst = rst; v.en = en; v.up = up; v.load = load; v.d = d;
        v.chk_tc = chk_tc; v.exp_tc = exp_tc; v.exp_q = exp_q; v.exp_le = exp_le;
        tv.push_back(v);
    endfunction

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] cur_q(logic sel);
        return sel ? {1'b0, bus_b.q} : bus_a.q;
    endfunction

    task automatic apply(vec_t v, int idx);
        exp_t e;
        logic tc;
        @(negedge clk);
        rst_a = 1'b0; bus_a.en = 1'b0; bus_a.up = 1'b1; bus_a.load = 1'b0; bus_a.d = '0;
        rst_b = 1'b0; bus_b.en = 1'b0; bus_b.up = 1'b1; bus_b.load = 1'b0; bus_b.d = '0;
        if (v.sel) begin
            rst_b = v.rst; bus_b.en = v.en; bus_b.up = v.up; bus_b.load = v.load; bus_b.d = v.d[2:0];
        end else begin
            rst_a = v.rst; bus_a.en = v.en; bus_a.up = v.up; bus_a.load = v.load; bus_a.d = v.d;
        end
        e.sel = v.sel; e.q = v.exp_q; e.le = v.exp_le; e.idx = idx;
        sb.push_back(e);
        #1;
        tc = v.sel ? bus_b.tc : bus_a.tc;
        if (v.chk_tc) chk($sformatf("tc[%0d]", idx), {3'b0, tc}, {3'b0, v.exp_tc});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("q[%0d]", e.idx), cur_q(e.sel), e.q);
        chk($sformatf("load_err[%0d]", e.idx),
            {3'b0, e.sel ? bus_b.load_err : bus_a.load_err}, {3'b0, e.le});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prev;
        vec_t v;
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.en = 0; bus_a.up = 1; bus_a.load = 0; bus_a.d = '0;
        bus_b.en = 0; bus_b.up = 1; bus_b.load = 0; bus_b.d = '0;

        // reset and hold
        add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 0, 0, 1, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 1, 1, 0, 0);   // reset with down-count enabled: tc = 1 at q=0
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);   // en=0 gates tc even at q=0 counting down
        // up count with wrap
        for (int i = 0; i < 12; i++)
            add(0, 0, 1, 1, 0, 0, 1, (i % 10) == 9, 4'((i + 1) % 10), 0);
        // down count with wrap
        add(0, 0, 0, 1, 1, 2, 1, 0, 2, 0);
        add(0, 0, 1, 0, 0, 0, 1, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 1, 1, 9, 0);
        add(0, 0, 1, 0, 0, 0, 1, 0, 8, 0);
        // load beats count; out-of-range loads
        add(0, 0, 1, 1, 1, 7, 1, 0, 7, 0);
        add(0, 0, 0, 1, 0, 0, 1, 0, 7, 0);
        add(0, 0, 0, 1, 1, 12, 1, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 10, 1, 0, 0, 1);
        add(0, 0, 0, 1, 1, 10, 1, 0, 0, 1);
        add(0, 0, 0, 1, 1, 9, 1, 0, 9, 0);
        // direction change takes effect on the same edge
        add(0, 0, 1, 1, 0, 0, 1, 1, 0, 0);
        add(0, 0, 1, 1, 0, 0, 1, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        // reset beats load mid-count
        add(0, 0, 0, 1, 1, 4, 1, 0, 4, 0);
        add(0, 0, 1, 1, 0, 0, 1, 0, 5, 0);
        add(0, 1, 1, 1, 1, 3, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 1, 0, 1, 0);
        add(0, 0, 1, 1, 0, 0, 1, 0, 2, 0);
        // full-range modulus W=3, MOD=8
        add(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++)
            add(1, 0, 1, 1, 0, 0, 1, i == 7, 4'((i + 1) % 8), 0);
        add(1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 1, 1, 7, 0);
        add(1, 0, 0, 1, 1, 5, 1, 0, 5, 0);

        for (int i = 0; i < tv.size(); i++) apply(tv[i], i);

        // toggle pattern at the 9 -> 0 wrap edge
        v = '{sel: 0, rst: 0, en: 0, up: 1, load: 1, d: 9, chk_tc: 1, exp_tc: 0, exp_q: 9, exp_le: 0};
        apply(v, 100);
        prev = bus_a.q;
        v = '{sel: 0, rst: 0, en: 1, up: 1, load: 0, d: 0, chk_tc: 1, exp_tc: 1, exp_q: 0, exp_le: 0};
        apply(v, 101);
        chk("t_pattern_wrap", prev ^ bus_a.q, 4'b1001);

        // toggle pattern on a 3 -> 4 increment
        v = '{sel: 0, rst: 0, en: 0, up: 1, load: 1, d: 3, chk_tc: 1, exp_tc: 0, exp_q: 3, exp_le: 0};
        apply(v, 102);
        prev = bus_a.q;
        v = '{sel: 0, rst: 0, en: 1, up: 1, load: 0, d: 0, chk_tc: 1, exp_tc: 0, exp_q: 4, exp_le: 0};
        apply(v, 103);
        chk("t_pattern_3to4", prev ^ bus_a.q, 4'b0111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
